// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper sequencer.
//   state_t    : sequencer FSM states (IDLE, RUN, DONE)
//   PH_W       : phase index width, 2 for full-step, 3 when HALF_STEP_EN is defined
//   FULL_TBL   : full-step coil patterns {A, B, A_n, B_n}, index 0..3
//   HALF_TBL   : half-step coil patterns, index 0..7
//   coil_pattern() : phase index -> coil pattern for the configured stepping mode
// Configuration macro: HALF_STEP_EN (half-stepping, 8-entry phase table).
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

`ifdef HALF_STEP_EN
  localparam int unsigned PH_W    = 3;
  localparam bit          HALF_EN = 1'b1;
`else
  localparam int unsigned PH_W    = 2;
  localparam bit          HALF_EN = 1'b0;
`endif

  // Packed tables: element [i] is the pattern for phase index i.
  localparam logic [3:0][3:0] FULL_TBL = {4'b1001, 4'b0011, 4'b0110, 4'b1100};
  localparam logic [7:0][3:0] HALF_TBL = {4'b1001, 4'b0001, 4'b0011, 4'b0010,
                                          4'b0110, 4'b0100, 4'b1100, 4'b1000};

  function automatic logic [3:0] coil_pattern(input logic [2:0] ph);
    if (HALF_EN) return HALF_TBL[ph];
    else         return FULL_TBL[ph[1:0]];
  endfunction

endpackage

// File: rtl/stepper_sequencer_if.sv
// Command/status bundle between the motion control logic and the sequencer.
//   start, dir, n_steps, abort : move command (master -> slave)
//   coils, busy, done, steps_left : coil drive and move status (slave -> master)
// Modports: master (control logic / bench), slave (stepper_sequencer).
interface stepper_sequencer_if #(
  parameter int unsigned STEP_W = 16
);
  logic              start;
  logic              dir;
  logic [STEP_W-1:0] n_steps;
  logic              abort;
  logic [3:0]        coils;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] steps_left;

  modport master (
    output start, dir, n_steps, abort,
    input  coils, busy, done, steps_left
  );

  modport slave (
    input  start, dir, n_steps, abort,
    output coils, busy, done, steps_left
  );
endinterface

// File: rtl/edge_sync.sv
// Two-flop synchroniser plus history flop producing a one-cycle pulse on each
// rising edge of an asynchronous input.
//   clk   : system clock
//   rst_n : synchronous reset, active-low (clears all three flops)
//   d     : asynchronous input
//   rise  : one-cycle pulse, high 2-3 clk after a rise of d
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic r_s1, r_s2, r_s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign rise = r_s2 & ~r_s3;
endmodule

// File: rtl/stepper_sequencer.sv
// Unipolar stepper motor sequencer. Each rising edge of step_clk (an
// asynchronous data input, not a clock) advances the motor one phase in the
// commanded direction until the commanded step count is exhausted or the
// move is aborted. Coils hold their last pattern between moves.
//   clk      : system clock
//   rst_n    : synchronous reset, active-low
//   step_clk : divided square wave from the clock divider
//   bus      : slave side of stepper_sequencer_if (command in, coils/status out)
// Configuration macro: HALF_STEP_EN selects 8-phase half-stepping.
module stepper_sequencer
  import stepper_pkg::*;
#(
  parameter int unsigned STEP_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 step_clk,
  stepper_sequencer_if.slave   bus
);

  state_t            r_state,  w_state_next;
  logic [PH_W-1:0]   r_phase,  w_phase_next;
  logic [PH_W-1:0]   w_phase_adv;
  logic              r_dir,    w_dir_next;
  logic [STEP_W-1:0] r_steps_left, w_steps_next;
  logic [3:0]        r_coils,  w_coils_next;
  logic              w_step_edge;

  edge_sync u_step_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (step_clk),
    .rise  (w_step_edge)
  );

  // Phase index wraps naturally at its width (mod 4 or mod 8).
  assign w_phase_adv = r_dir ? r_phase + PH_W'(1) : r_phase - PH_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_phase      <= '0;
      r_dir        <= 1'b0;
      r_steps_left <= '0;
      r_coils      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_phase      <= w_phase_next;
      r_dir        <= w_dir_next;
      r_steps_left <= w_steps_next;
      r_coils      <= w_coils_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_dir_next   = r_dir;
    w_steps_next = r_steps_left;
    w_coils_next = r_coils;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (bus.n_steps != '0) begin
            w_dir_next   = bus.dir;
            w_steps_next = bus.n_steps;
            w_coils_next = coil_pattern(3'(r_phase));
            w_state_next = RUN;
          end else begin
            w_state_next = DONE;
          end
        end
      end
      RUN: begin
        // Abort takes priority so a coincident edge never moves the motor.
        if (bus.abort) begin
          w_state_next = DONE;
        end else if (w_step_edge) begin
          w_phase_next = w_phase_adv;
          w_coils_next = coil_pattern(3'(w_phase_adv));
          w_steps_next = r_steps_left - STEP_W'(1);
          if (r_steps_left == STEP_W'(1)) w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign bus.coils      = r_coils;
  assign bus.busy       = (r_state == RUN);
  assign bus.done       = (r_state == DONE);
  assign bus.steps_left = r_steps_left;

endmodule
